// File: rtl/tea_ptxt_packer.sv
// Packs a byte stream into 64-bit plaintext blocks and assembles a 128-bit key
// from four 32-bit words, presenting both to a downstream TEA encryptor.
module tea_ptxt_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         byte_last,
  output logic         byte_ready,
  input  logic [31:0]  key_word,
  input  logic         key_word_valid,
  output logic         key_word_ready,
  output logic [63:0]  ptxt_blk,
  output logic         ptxt_valid,
  output logic [127:0] key,
  output logic         key_valid,
  output logic         blk_last,
  output logic [15:0]  blk_count
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PEND = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [63:0]    blk_q, blk_d;
  logic           last_q, last_d;
  logic [15:0]    bcnt_q, bcnt_d;
  logic           pvld_q, pvld_d;
  logic [127:0]   key_q, key_d;
  logic [1:0]     kcnt_q, kcnt_d;
  logic           kvld_q, kvld_d;

  logic           byte_xfer;
  logic           key_xfer;
  logic           blk_done;
  logic           key_ok;

  assign byte_ready     = (state_q == FILL);
  assign key_word_ready = (state_q != EMIT);
  assign byte_xfer      = byte_valid && byte_ready;
  assign key_xfer       = key_word_valid && key_word_ready;
  assign blk_done       = byte_xfer && ((cnt_q == 3'd7) || byte_last);
  // A key restart in the same cycle invalidates the key, so it must not be emitted.
  assign key_ok         = kvld_q && kvld_d;

  always_comb begin
    key_d  = key_q;
    kcnt_d = kcnt_q;
    kvld_d = kvld_q;
    if (key_xfer) begin
      if (kvld_q) begin
        key_d[127:96] = key_word;
        kcnt_d        = 2'd1;
        kvld_d        = 1'b0;
      end else begin
        key_d[127 - 32*int'(kcnt_q) -: 32] = key_word;
        kcnt_d = kcnt_q + 2'd1;
        kvld_d = (kcnt_q == 2'd3);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      FILL: begin
        if (byte_xfer) begin
          blk_d[63 - 8*int'(cnt_q) -: 8] = byte_in;
          if (blk_done) begin
            last_d  = byte_last;
            state_d = key_ok ? EMIT : PEND;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      PEND: begin
        if (key_ok) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        state_d = FILL;
        cnt_d   = 3'd0;
        blk_d   = {8{PAD_BYTE}};
        last_d  = 1'b0;
        bcnt_d  = bcnt_q + 16'd1;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign pvld_d = (state_d == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= 3'd0;
      blk_q   <= {8{PAD_BYTE}};
      last_q  <= 1'b0;
      bcnt_q  <= 16'd0;
      pvld_q  <= 1'b0;
      key_q   <= 128'd0;
      kcnt_q  <= 2'd0;
      kvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      pvld_q  <= pvld_d;
      key_q   <= key_d;
      kcnt_q  <= kcnt_d;
      kvld_q  <= kvld_d;
    end
  end

  assign ptxt_blk   = blk_q;
  assign ptxt_valid = pvld_q;
  assign blk_last   = last_q;
  assign blk_count  = bcnt_q;
  assign key        = key_q;
  assign key_valid  = kvld_q;

endmodule

// File: tb/tb_tea_ptxt_packer.sv
// Directed bench for tea_ptxt_packer: a byte-packing model feeds a scoreboard
// that is drained by a monitor on every ptxt_valid pulse.
module tb_tea_ptxt_packer;

  localparam logic [7:0] PAD = 8'h00;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_last;
  logic         byte_ready;
  logic [31:0]  key_word;
  logic         key_word_valid;
  logic         key_word_ready;
  logic [63:0]  ptxt_blk;
  logic         ptxt_valid;
  logic [127:0] key;
  logic         key_valid;
  logic         blk_last;
  logic [15:0]  blk_count;

  tea_ptxt_packer #(.PAD_BYTE(PAD)) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_last      (byte_last),
    .byte_ready     (byte_ready),
    .key_word       (key_word),
    .key_word_valid (key_word_valid),
    .key_word_ready (key_word_ready),
    .ptxt_blk       (ptxt_blk),
    .ptxt_valid     (ptxt_valid),
    .key            (key),
    .key_valid      (key_valid),
    .blk_last       (blk_last),
    .blk_count      (blk_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] blk;
    logic        last;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          mon_seen = 0;
  logic        prev_pv = 1'b0;

  logic [63:0] m_blk = {8{PAD}};
  int          m_k = 0;
  logic [15:0] m_cnt = 16'd0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ptxt_valid) begin
      chk("no_back_to_back", prev_pv, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_emit", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("emit_blk", ptxt_blk, e.blk);
        chk("emit_last", blk_last, e.last);
        chk("emit_count", blk_count, e.cnt);
      end
      mon_seen++;
    end
    prev_pv = ptxt_valid;
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    byte_last  = l;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("byte_ready_timeout", n, 0);
    end else begin
      @(posedge clk);
      @(negedge clk);
      m_blk[63 - 8*m_k -: 8] = b;
      if (m_k == 7 || l) begin
        sb.push_back('{blk: m_blk, last: l, cnt: m_cnt});
        m_cnt = m_cnt + 16'd1;
        m_blk = {8{PAD}};
        m_k   = 0;
      end else begin
        m_k++;
      end
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic send_key(input logic [31:0] w);
    int n = 0;
    key_word       = w;
    key_word_valid = 1'b1;
    while (!key_word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("key_ready_timeout", n, 0);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    key_word_valid = 1'b0;
  endtask

  task automatic wait_emits(input int target);
    int n = 0;
    #1;
    while (mon_seen < target && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("emit_wait", mon_seen, target);
  endtask

  task automatic post_emit(input string tag);
    @(posedge clk);
    #1;
    chk(tag, blk_count, m_cnt);
    chk({tag, "_pv_low"}, ptxt_valid, 1'b0);
    chk({tag, "_pad"}, ptxt_blk, {8{PAD}});
    chk({tag, "_last_clr"}, blk_last, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    byte_in        = 8'h00;
    byte_valid     = 1'b0;
    byte_last      = 1'b0;
    key_word       = 32'h0;
    key_word_valid = 1'b0;

    // Reset values, held across a clock edge
    #2;
    chk("rst_ptxt_blk", ptxt_blk, {8{PAD}});
    chk("rst_ptxt_valid", ptxt_valid, 1'b0);
    chk("rst_key", key, 128'd0);
    chk("rst_key_valid", key_valid, 1'b0);
    #5;
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_count", blk_count, 16'd0);
    chk("rst_byte_ready", byte_ready, 1'b1);
    chk("rst_key_ready", key_word_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // All-zero key and an all-zero final block
    for (int i = 0; i < 4; i++) send_key(32'h0);
    chk("k0_valid", key_valid, 1'b1);
    chk("k0_key", key, 128'd0);
    for (int i = 0; i < 8; i++) send_byte(8'h00, i == 7);
    chk("k0_latency", ptxt_valid, 1'b1);
    chk("k0_blk", ptxt_blk, 64'h0);
    chk("k0_last", blk_last, 1'b1);
    wait_emits(1);
    post_emit("k0_count");

    // Eleven bytes: one full block then a padded short block
    for (int i = 1; i <= 11; i++) begin
      send_byte(8'(i), i == 11);
      if (i == 8) begin
        chk("b1_latency", ptxt_valid, 1'b1);
        chk("b1_blk", ptxt_blk, 64'h0102030405060708);
        chk("b1_last", blk_last, 1'b0);
      end
    end
    chk("b2_blk", ptxt_blk, 64'h090A0B0000000000);
    chk("b2_last", blk_last, 1'b1);
    wait_emits(3);
    post_emit("b2_count");

    // Key restart, then a full block waits in PEND for the new key
    send_key(32'h12345678);
    chk("restart_kv", key_valid, 1'b0);
    chk("restart_w0", key[127:96], 32'h12345678);
    for (int i = 0; i < 8; i++) send_byte(8'hAA, 1'b0);
    chk("pend_ready", byte_ready, 1'b0);
    chk("pend_pv", ptxt_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("pend_hold_pv", ptxt_valid, 1'b0);
    chk("pend_hold_blk", ptxt_blk, 64'hAAAAAAAAAAAAAAAA);
    chk("pend_no_emit", mon_seen, 3);
    send_key(32'h9ABCDEF0);
    chk("restart_kv_1", key_valid, 1'b0);
    send_key(32'h0F1E2D3C);
    send_key(32'h4B5A6978);
    chk("reload_kv", key_valid, 1'b1);
    chk("reload_pv_wait", ptxt_valid, 1'b0);
    chk("reload_key", key, 128'h123456789ABCDEF00F1E2D3C4B5A6978);
    @(negedge clk);
    chk("pend_emit_pv", ptxt_valid, 1'b1);
    chk("pend_emit_blk", ptxt_blk, 64'hAAAAAAAAAAAAAAAA);
    wait_emits(4);
    post_emit("pend_count");

    // Asynchronous reset in the middle of a block
    for (int i = 1; i <= 4; i++) send_byte(8'(8'h11 * i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_blk", ptxt_blk, {8{PAD}});
    chk("arst_key", key, 128'd0);
    chk("arst_kv", key_valid, 1'b0);
    chk("arst_count", blk_count, 16'd0);
    chk("arst_ready", byte_ready, 1'b1);
    m_blk = {8{PAD}};
    m_k   = 0;
    m_cnt = 16'd0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_key(32'hC0DE0000 + i);
    chk("arst_newkey", key, 128'hC0DE0000C0DE0001C0DE0002C0DE0003);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
    chk("arst_fresh_blk", ptxt_blk, 64'h1011121314151617);
    wait_emits(5);
    post_emit("arst_fresh_count");

    // Back-to-back single-byte blocks
    for (int i = 0; i < 20; i++) send_byte(8'(8'hB0 + i), 1'b1);
    wait_emits(25);
    post_emit("burst_count");

    // Counter wrap, starting two blocks below the top
    force dut.bcnt_q = 16'hFFFE;
    #1;
    release dut.bcnt_q;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'hE0 + i), 1'b1);
      wait_emits(26 + i);
      post_emit("wrap_count");
    end
    chk("wrap_final", blk_count, 16'h0001);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tea_ptxt_packer.md
TEA_PTXT_PACKER -- requirements
Module: tea_ptxt_packer

Interface
REQ-001 Parameter: PAD_BYTE, 8'h00, fill value for unused byte lanes of a short final block.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 byte_in  input  8  message byte.
REQ-005 byte_valid  input  1  byte_in valid this cycle.
REQ-006 byte_last  input  1  qualifies byte_in as final byte of message.
REQ-007 byte_ready  output  1  packer accepts a byte this cycle.
REQ-008 key_word  input  32  key word, most significant word first.
REQ-009 key_word_valid  input  1  key_word valid this cycle.
REQ-010 key_word_ready  output  1  packer accepts a key word this cycle.
REQ-011 ptxt_blk  output  64  plaintext block to encryptor.
REQ-012 ptxt_valid  output  1  ptxt_blk valid; high exactly one cycle per block.
REQ-013 key  output  128  assembled key to encryptor.
REQ-014 key_valid  output  1  all four key words loaded.
REQ-015 blk_last  output  1  block in ptxt_blk is the final block of a message.
REQ-016 blk_count  output  16  number of blocks emitted since reset.

Function
REQ-017 All outputs registered; no combinational path from any input to any output except byte_ready/key_word_ready, which decode state only.
REQ-018 States: FILL, PEND, EMIT; reset state FILL.
REQ-019 Byte handshake: transfer when byte_valid && byte_ready; byte_ready = (state == FILL).
REQ-020 Byte order: k-th accepted byte of block (k = 0..7) written to ptxt_blk[63-8k -: 8]; byte 0 lands in [63:56].
REQ-021 Byte counter 3 bits, 0..7; cleared on every exit from EMIT.
REQ-022 Block completes on transfer of byte k=7 or on transfer of any byte with byte_last=1.
REQ-023 Short final block: lanes k+1..7 hold PAD_BYTE; blk_last=1.
REQ-024 Full block with byte_last on k=7: no padding, blk_last=1; full block without byte_last: blk_last=0.
REQ-025 FILL -> EMIT on completing transfer when key_valid=1; FILL -> PEND on completing transfer when key_valid=0.
REQ-026 PEND -> EMIT in the cycle after key_valid is observed 1; PEND holds ptxt_blk, blk_last unchanged, ptxt_valid=0.
REQ-027 EMIT lasts one cycle: ptxt_valid=1, ptxt_blk/key/blk_last stable; EMIT -> FILL unconditionally.
REQ-028 Latency: ptxt_valid rises the cycle after the completing byte transfer when key already valid.
REQ-029 On EMIT exit: ptxt_blk lanes reset to PAD_BYTE, blk_last cleared, blk_count increments by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-030 Key handshake: transfer when key_word_valid && key_word_ready; key_word_ready = (state != EMIT).
REQ-031 Key word counter 2 bits; word j (j = 0..3) written to key[127-32j -: 32]; key_valid set on transfer of word 3.
REQ-032 Key word transferred while key_valid=1: key_valid cleared, word stored as word 0, counter = 1 (new key load restarts).
REQ-033 Key load in PEND is legal; EMIT waits until key_valid=1 again.
REQ-034 Byte and key transfers in the same cycle are both accepted independently.

Reset
REQ-035 While rst=1 (asynchronous assert): state FILL, counters 0, ptxt_blk all lanes PAD_BYTE, key 0, key_valid 0, ptxt_valid 0, blk_last 0, blk_count 0.
REQ-036 Reset mid-block or in PEND/EMIT discards partial block and key; no ptxt_valid pulse follows reset release until a new block completes.
REQ-037 First transfers accepted on the first rising edge with rst=0.

Verification
REQ-038 Load key words 0,0,0,0 then 8 bytes 00 with byte_last on 8th -> one ptxt_valid pulse, ptxt_blk=64'h0, blk_last=1, blk_count=1; downstream ctxt_blk=64'h41ea3a0a94baa940.
REQ-039 Key valid; bytes 01..0B, byte_last on 0B -> block 1 = 64'h0102030405060708 blk_last=0, block 2 = 64'h090A0B0000000000 blk_last=1.
REQ-040 No key; 8 bytes AA -> PEND, byte_ready=0, no ptxt_valid; load 4 key words -> ptxt_valid one cycle after key_valid rises, ptxt_blk=64'hAAAAAAAAAAAAAAAA.
REQ-041 Key valid, 5th key word 32'h12345678 -> key_valid=0 until three more words; key[127:96]=32'h12345678.
REQ-042 Assert rst after 4 bytes accepted -> all outputs at reset values; next 8 bytes form a fresh block, blk_count=1.
REQ-043 Emit 65536 blocks -> blk_count wraps to 0; ptxt_valid never high two consecutive cycles.
